srio_type9_dstream_rx: RTL and testbench

Receive-side counterpart of the type 9 data-streaming transmit path. Takes SRIO Gen2 target-request (treq) segment packets from the core and reassembles one PDU at a time onto a user AXI-Stream. Header beats are stripped and payload is concatenated, with tlast only on the PDU's final beat. Malformed, orphaned and non-type-9 traffic is dropped and flagged.

---
 rtl/srio_type9_dstream_rx.sv | 181 ++++++++++++++++++
 tb/tb_srio_type9_dstream_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/srio_type9_dstream_rx.sv
// SRIO type 9 data-streaming receive: reassembles treq segments into PDUs.
// Header beats are stripped; the last payload beat is held until its fate is known.
module srio_type9_dstream_rx #(
  parameter bit LEN_CHECK = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             treq_tvalid,
  output logic             treq_tready,
  input  logic             treq_tlast,
  input  logic [63:0]      treq_tdata,
  input  logic [7:0]       treq_tkeep,
  input  logic [31:0]      treq_tuser,
  output logic             user_treq_tvalid,
  input  logic             user_treq_tready,
  output logic             user_treq_tlast,
  output logic [63:0]      user_treq_tdata,
  output logic [7:0]       user_treq_tkeep,
  output logic [31:0]      user_treq_tuser,
  output logic             err_len,
  output logic             err_abort,
  output logic             err_orphan,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {HDR, DATA, DISCARD} state_t;

  state_t state, state_nx;

  logic        active;
  logic [15:0] stream_id;
  logic [15:0] src_id;
  logic [31:0] tuser_cap;
  logic [16:0] byte_cnt;
  logic        seg_e;
  logic [15:0] seg_len;

  logic        hold_valid;
  logic        hold_last;
  logic        hold_err;
  logic [63:0] hold_data;
  logic [7:0]  hold_keep;

  function automatic logic [3:0] popcnt(input logic [7:0] k);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, k[i]};
    return c;
  endfunction

  logic        h_ft9, h_s, h_e, h_match;
  logic [15:0] h_sid, h_len, h_src;
  logic        hdr_rel, dat_disp;
  logic        acc, out_fire, hdr_acc, dat_acc;
  logic        is_abort, is_orphan, is_drop, is_close;
  logic        close_err, dat_final;
  logic [3:0]  add;
  logic [16:0] cnt_sum;
  logic        unused;

  assign h_ft9   = treq_tdata[55:52] == 4'd9;
  assign h_s     = treq_tdata[51];
  assign h_e     = treq_tdata[50];
  assign h_sid   = treq_tdata[47:32];
  assign h_len   = treq_tdata[15:0];
  assign h_src   = treq_tuser[31:16];
  assign h_match = active && h_sid == stream_id
                   && h_src == src_id;
  assign unused  = ^{treq_tdata[63:56],
                     treq_tdata[49:48],
                     treq_tdata[31:16]};

  // A held beat is only shown once we know whether it ends the PDU
  assign hdr_rel  = state == HDR && treq_tvalid
                    && h_ft9 && active
                    && (h_s || (h_match && treq_tlast && h_e));
  assign dat_disp = state == DATA && treq_tvalid;

  assign user_treq_tvalid = hold_valid
                            && (hold_last || dat_disp || hdr_rel);
  assign user_treq_tlast  = hold_last || hdr_rel;
  assign user_treq_tdata  = hold_data;
  assign user_treq_tkeep  = hold_keep;
  assign user_treq_tuser  = tuser_cap;

  assign treq_tready = !reset
                       && (!hold_valid || user_treq_tready
                           || !user_treq_tvalid);

  assign acc      = treq_tvalid && treq_tready;
  assign out_fire = user_treq_tvalid && user_treq_tready;
  assign hdr_acc  = acc && state == HDR;
  assign dat_acc  = acc && state == DATA;

  assign is_abort  = hdr_acc && h_ft9 && h_s && active;
  assign is_orphan = hdr_acc && h_ft9 && !h_s && !h_match;
  assign is_drop   = hdr_acc && (!h_ft9 || (!h_s && !h_match));
  assign is_close  = hdr_acc && h_ft9 && treq_tlast && h_e
                     && (h_s || h_match);

  assign close_err = h_s ? 1'b1
                   : hold_valid ? (LEN_CHECK && byte_cnt != {1'b0, h_len})
                   : 1'b1;

  assign add       = treq_tlast ? popcnt(treq_tkeep) : 4'd8;
  assign cnt_sum   = byte_cnt + {13'd0, add};
  assign dat_final = dat_acc && treq_tlast && seg_e;

  assign err_abort  = is_abort;
  assign err_orphan = is_orphan;
  assign err_len    = (out_fire && hold_last && hold_err)
                      || (is_close && close_err);

  always_comb begin
    state_nx = state;
    unique case (state)
      HDR: begin
        if (hdr_acc && !treq_tlast)
          state_nx = is_drop ? DISCARD : DATA;
      end
      DATA: begin
        if (dat_acc && treq_tlast) state_nx = HDR;
      end
      DISCARD: begin
        if (acc && treq_tlast) state_nx = HDR;
      end
      default: state_nx = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HDR;
      active     <= 1'b0;
      stream_id  <= '0;
      src_id     <= '0;
      tuser_cap  <= '0;
      byte_cnt   <= '0;
      seg_e      <= 1'b0;
      seg_len    <= '0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      hold_err   <= 1'b0;
      hold_data  <= '0;
      hold_keep  <= '0;
      drop_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (hdr_acc && h_ft9 && h_s) begin
        stream_id <= h_sid;
        src_id    <= h_src;
        tuser_cap <= treq_tuser;
        byte_cnt  <= '0;
        active    <= 1'b1;
      end
      if (hdr_acc && h_ft9 && (h_s || h_match)) begin
        seg_e   <= h_e;
        seg_len <= h_len;
      end
      if (is_close) active <= 1'b0;
      if (dat_acc) byte_cnt <= cnt_sum;
      if (dat_final) active <= 1'b0;
      if (is_drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
      if (dat_acc) begin
        hold_valid <= 1'b1;
        hold_data  <= treq_tdata;
        hold_keep  <= dat_final ? treq_tkeep : 8'hFF;
        hold_last  <= dat_final;
        hold_err   <= dat_final && LEN_CHECK
                      && cnt_sum != {1'b0, seg_len};
      end else if (out_fire) begin
        hold_valid <= 1'b0;
        hold_last  <= 1'b0;
        hold_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_srio_type9_dstream_rx.sv
// Directed bench for srio_type9_dstream_rx.
// Output beats are logged at negedge and compared with hand-built expectations.
module tb_srio_type9_dstream_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        treq_tvalid = 1'b0;
  logic        treq_tready;
  logic        treq_tlast = 1'b0;
  logic [63:0] treq_tdata = '0;
  logic [7:0]  treq_tkeep = '0;
  logic [31:0] treq_tuser = '0;
  logic        user_treq_tvalid;
  logic        user_treq_tready = 1'b1;
  logic        user_treq_tlast;
  logic [63:0] user_treq_tdata;
  logic [7:0]  user_treq_tkeep;
  logic [31:0] user_treq_tuser;
  logic        err_len, err_abort, err_orphan;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  srio_type9_dstream_rx #(.LEN_CHECK(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .treq_tvalid(treq_tvalid), .treq_tready(treq_tready),
    .treq_tlast(treq_tlast), .treq_tdata(treq_tdata),
    .treq_tkeep(treq_tkeep), .treq_tuser(treq_tuser),
    .user_treq_tvalid(user_treq_tvalid),
    .user_treq_tready(user_treq_tready),
    .user_treq_tlast(user_treq_tlast),
    .user_treq_tdata(user_treq_tdata),
    .user_treq_tkeep(user_treq_tkeep),
    .user_treq_tuser(user_treq_tuser),
    .err_len(err_len), .err_abort(err_abort),
    .err_orphan(err_orphan), .drop_cnt(drop_cnt)
  );

  logic [107:0] obs_q[$];
  int n_elen = 0, n_eab = 0, n_eor = 0, n_stall = 0;
  int x_len = 0, x_ab = 0, x_or = 0;
  int n_chk = 0, n_fail = 0, rd = 0;
  bit tog = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (user_treq_tvalid && user_treq_tready)
        obs_q.push_back({user_treq_tuser, 3'b0, user_treq_tlast,
                         user_treq_tkeep, user_treq_tdata});
      if (err_len) n_elen <= n_elen + 1;
      if (err_abort) n_eab <= n_eab + 1;
      if (err_orphan) n_eor <= n_eor + 1;
      if (treq_tvalid && !treq_tready) n_stall <= n_stall + 1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog) user_treq_tready = ~user_treq_tready;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic l,
                      input logic [7:0] k, input logic [31:0] u);
    int n;
    n = 0;
    treq_tvalid = 1'b1;
    treq_tdata  = d;
    treq_tlast  = l;
    treq_tkeep  = k;
    treq_tuser  = u;
    @(negedge clk);
    while (!treq_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!treq_tready) chk("tready_timeout", {127'd0, treq_tready}, 128'd1);
    @(posedge clk);
    #1;
    treq_tvalid = 1'b0;
  endtask

  function automatic logic [63:0] hdr(input logic [3:0] ft,
      input logic s, input logic e,
      input logic [15:0] sid, input logic [15:0] len);
    logic [63:0] h;
    h = '0;
    h[55:52] = ft;
    h[51] = s;
    h[50] = e;
    h[47:32] = sid;
    h[15:0] = len;
    return h;
  endfunction

  task automatic seg(input logic [63:0] h, input logic [31:0] u,
                     input int n, input logic [63:0] base,
                     input logic [7:0] lk);
    send(h, n == 0, 8'hFF, u);
    for (int i = 0; i < n; i++)
      send(base + 64'(i), i == n - 1, (i == n - 1) ? lk : 8'hFF, u);
  endtask

  task automatic expb(input string tag, input logic [63:0] d,
                      input logic l, input logic [7:0] k,
                      input logic [31:0] u);
    logic [107:0] g;
    if (rd < obs_q.size()) g = obs_q[rd];
    else g = 'x;
    rd++;
    chk(tag, {20'd0, g}, {20'd0, u, 3'b0, l, k, d});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_tail(input string tag);
    chk({tag, "_beats"}, 128'(obs_q.size()), 128'(rd));
    chk({tag, "_elen"}, 128'(n_elen), 128'(x_len));
    chk({tag, "_eabort"}, 128'(n_eab), 128'(x_ab));
    chk({tag, "_eorphan"}, 128'(n_eor), 128'(x_or));
  endtask

  initial begin
    int s0;
    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", {127'd0, treq_tready}, 128'd0);
    chk("rst_uvalid", {127'd0, user_treq_tvalid}, 128'd0);
    chk("rst_udata", {64'd0, user_treq_tdata}, 128'd0);
    chk("rst_drop", {112'd0, drop_cnt}, 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", {127'd0, treq_tready}, 128'd1);
    idle(1);

    // T1: single segment, 20 bytes
    seg(hdr(4'd9, 1, 1, 16'h0001, 16'd20), 32'h0011_0022, 3,
        64'hA100_0000_0000_0000, 8'h0F);
    idle(6);
    expb("t1_b0", 64'hA100_0000_0000_0000, 0, 8'hFF, 32'h0011_0022);
    expb("t1_b1", 64'hA100_0000_0000_0001, 0, 8'hFF, 32'h0011_0022);
    expb("t1_b2", 64'hA100_0000_0000_0002, 1, 8'h0F, 32'h0011_0022);
    chk_tail("t1");

    // T2: start/middle/end, stream 0x0042, 40 bytes
    seg(hdr(4'd9, 1, 0, 16'h0042, 16'd0), 32'h0033_0044, 2,
        64'hB200_0000_0000_0000, 8'hFF);
    seg(hdr(4'd9, 0, 0, 16'h0042, 16'd0), 32'h0033_9999, 2,
        64'hB200_0000_0000_0002, 8'hFF);
    seg(hdr(4'd9, 0, 1, 16'h0042, 16'd40), 32'h0033_9999, 1,
        64'hB200_0000_0000_0004, 8'hFF);
    idle(6);
    for (int i = 0; i < 5; i++)
      expb("t2_beat", 64'hB200_0000_0000_0000 + 64'(i), i == 4,
           8'hFF, 32'h0033_0044);
    chk_tail("t2");

    // T3: same with output ready toggling
    s0 = n_stall;
    tog = 1'b1;
    seg(hdr(4'd9, 1, 0, 16'h0042, 16'd0), 32'h0033_0044, 2,
        64'hC300_0000_0000_0000, 8'hFF);
    seg(hdr(4'd9, 0, 0, 16'h0042, 16'd0), 32'h0033_0044, 2,
        64'hC300_0000_0000_0002, 8'hFF);
    seg(hdr(4'd9, 0, 1, 16'h0042, 16'd40), 32'h0033_0044, 1,
        64'hC300_0000_0000_0004, 8'hFF);
    idle(10);
    tog = 1'b0;
    user_treq_tready = 1'b1;
    idle(2);
    for (int i = 0; i < 5; i++)
      expb("t3_beat", 64'hC300_0000_0000_0000 + 64'(i), i == 4,
           8'hFF, 32'h0033_0044);
    chk("t3_stall_seen", {127'd0, n_stall > s0}, 128'd1);
    chk_tail("t3");

    // T4: orphan middle segment
    seg(hdr(4'd9, 0, 0, 16'h0042, 16'd0), 32'h0033_0044, 1,
        64'hD400_0000_0000_0000, 8'hFF);
    idle(4);
    x_or = 1;
    chk("t4_drop", {112'd0, drop_cnt}, 128'd1);
    chk_tail("t4");

    // T5: FTYPE 8 packet inside a PDU
    seg(hdr(4'd9, 1, 0, 16'h0007, 16'd0), 32'h0055_0066, 2,
        64'hE500_0000_0000_0000, 8'hFF);
    seg(hdr(4'd8, 0, 0, 16'h0007, 16'd0), 32'h0055_0066, 1,
        64'hF800_0000_0000_0000, 8'hFF);
    seg(hdr(4'd9, 0, 1, 16'h0007, 16'd24), 32'h0055_0066, 1,
        64'hE500_0000_0000_0002, 8'hFF);
    idle(6);
    for (int i = 0; i < 3; i++)
      expb("t5_beat", 64'hE500_0000_0000_0000 + 64'(i), i == 2,
           8'hFF, 32'h0055_0066);
    chk("t5_drop", {112'd0, drop_cnt}, 128'd2);
    chk_tail("t5");

    // T6: new start truncates an open PDU
    seg(hdr(4'd9, 1, 0, 16'h0005, 16'd0), 32'h0077_0001, 2,
        64'hA600_0000_0000_0000, 8'hFF);
    seg(hdr(4'd9, 1, 1, 16'h0006, 16'd8), 32'h0077_0002, 1,
        64'hB600_0000_0000_0000, 8'hFF);
    idle(6);
    x_ab = 1;
    expb("t6_a0", 64'hA600_0000_0000_0000, 0, 8'hFF, 32'h0077_0001);
    expb("t6_a1", 64'hA600_0000_0000_0001, 1, 8'hFF, 32'h0077_0001);
    expb("t6_b0", 64'hB600_0000_0000_0000, 1, 8'hFF, 32'h0077_0002);
    chk_tail("t6");

    // T7: length 24 declared, 32 bytes received
    seg(hdr(4'd9, 1, 1, 16'h0009, 16'd24), 32'h0088_0099, 4,
        64'hC700_0000_0000_0000, 8'hFF);
    idle(6);
    x_len = 1;
    for (int i = 0; i < 4; i++)
      expb("t7_beat", 64'hC700_0000_0000_0000 + 64'(i), i == 3,
           8'hFF, 32'h0088_0099);
    chk_tail("t7");
    chk("final_drop", {112'd0, drop_cnt}, 128'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
